// File: rtl/audio_pkg.sv
// Shared audio types and defaults for the codec-side DAC serializer and future ADC deserializer.
package audio_pkg;
  localparam int DATA_W      = 24;
  localparam int FIFO_DEPTH  = 8;
  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } stereo_sample_t;

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } dac_state_t;
endpackage

// File: rtl/audio_dac_serializer_if.sv
// Stereo sample write handshake between a producer (master) and the DAC serializer (slave).
interface audio_dac_serializer_if #(
  parameter int DATA_W = audio_pkg::DATA_W
);
  logic              write;
  logic [DATA_W-1:0] writedata_left;
  logic [DATA_W-1:0] writedata_right;
  logic              write_ready;

  modport master (output write, writedata_left, writedata_right, input write_ready);
  modport slave  (input write, writedata_left, writedata_right, output write_ready);
endinterface

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO of stereo pairs; push while full and pop while empty are ignored.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int  DEPTH   = FIFO_DEPTH,
  parameter type entry_t = stereo_sample_t
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer slaved to external BCLK/LRCK; buffers stereo pairs and shifts them MSB first.
//   state    | meaning
//   ST_ALIGN | waiting for a left-frame start, output held at 0
//   ST_LEFT  | shifting the left sample of the current frame
//   ST_RIGHT | shifting the right sample of the current frame
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W      = audio_pkg::DATA_W,
  parameter int FIFO_DEPTH  = audio_pkg::FIFO_DEPTH,
  parameter int SYNC_STAGES = audio_pkg::SYNC_STAGES
) (
  input  logic                        CLOCK_50,
  input  logic                        reset_n,
  audio_dac_serializer_if.slave       wr,
  input  logic                        AUD_BCLK,
  input  logic                        AUD_DACLRCK,
  output logic                        AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        underflow
);
  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } pair_t;

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [1:0]             rst_sync;
  logic                   rst_n_int;
  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic                   bclk_s, lrck_s, bclk_d, lr_prev;
  logic                   bclk_fall, left_edge, right_edge;
  dac_state_t             state, state_nxt;
  logic                   pop_req, load_left, load_right, kill;
  logic [DATA_W-1:0]      shifter, right_hold;
  logic [CNT_W-1:0]       bit_cnt;
  pair_t                  push_pair, fifo_pair, head;
  logic                   fifo_full, fifo_empty;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  always_ff @(posedge CLOCK_50 or negedge rst_n_int) begin
    if (!rst_n_int) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_d    <= 1'b0;
      lr_prev   <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
      bclk_d    <= bclk_s;
      if (bclk_fall) lr_prev <= lrck_s;
    end
  end

  assign bclk_s     = bclk_sync[SYNC_STAGES-1];
  assign lrck_s     = lrck_sync[SYNC_STAGES-1];
  assign bclk_fall  = bclk_d & ~bclk_s;
  assign left_edge  = bclk_fall & lr_prev & ~lrck_s;
  assign right_edge = bclk_fall & ~lr_prev & lrck_s;

  always_ff @(posedge CLOCK_50 or negedge rst_n_int) begin
    if (!rst_n_int) state <= ST_ALIGN;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pop_req    = 1'b0;
    load_left  = 1'b0;
    load_right = 1'b0;
    kill       = 1'b0;
    case (state)
      ST_ALIGN: begin
        if (left_edge) begin
          pop_req   = 1'b1;
          load_left = 1'b1;
          state_nxt = ST_LEFT;
        end
      end
      ST_LEFT: begin
        if (right_edge) begin
          load_right = 1'b1;
          state_nxt  = ST_RIGHT;
        end else if (left_edge) begin
          kill      = 1'b1;
          state_nxt = ST_ALIGN;
        end
      end
      ST_RIGHT: begin
        if (left_edge) begin
          pop_req   = 1'b1;
          load_left = 1'b1;
          state_nxt = ST_LEFT;
        end else if (right_edge) begin
          kill      = 1'b1;
          state_nxt = ST_ALIGN;
        end
      end
      default: begin
        kill      = 1'b1;
        state_nxt = ST_ALIGN;
      end
    endcase
  end

  assign head      = fifo_empty ? '0 : fifo_pair;
  assign underflow = pop_req & fifo_empty;

  // Loading on the edge-detect fall leaves DACDAT untouched, giving the I2S one-bit delay.
  always_ff @(posedge CLOCK_50 or negedge rst_n_int) begin
    if (!rst_n_int) begin
      shifter    <= '0;
      right_hold <= '0;
      bit_cnt    <= '0;
      AUD_DACDAT <= 1'b0;
    end else if (load_left) begin
      shifter    <= head.left;
      right_hold <= head.right;
      bit_cnt    <= CNT_W'(DATA_W);
    end else if (load_right) begin
      shifter <= right_hold;
      bit_cnt <= CNT_W'(DATA_W);
    end else if (kill) begin
      bit_cnt    <= '0;
      AUD_DACDAT <= 1'b0;
    end else if (bclk_fall) begin
      if (bit_cnt != '0) begin
        AUD_DACDAT <= shifter[DATA_W-1];
        shifter    <= {shifter[DATA_W-2:0], 1'b0};
        bit_cnt    <= bit_cnt - 1'b1;
      end else begin
        AUD_DACDAT <= 1'b0;
      end
    end
  end

  assign push_pair.left  = wr.writedata_left;
  assign push_pair.right = wr.writedata_right;
  assign wr.write_ready  = ~fifo_full;

  audio_sample_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (pair_t)
  ) u_fifo (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (rst_n_int),
    .push      (wr.write),
    .push_data (push_pair),
    .pop       (pop_req),
    .pop_data  (fifo_pair),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );
endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
Codec-side responder for the audio write handshake. It accepts stereo samples on write/writedata_left/writedata_right with write_ready backpressure, buffers them in a small FIFO, and serializes them I2S-style onto AUD_DACDAT. It is timed by the externally supplied AUD_BCLK and AUD_DACLRCK, which are treated as slave inputs. It replaces the DAC half of the vendor codec so that producer modules (mic passthrough, ROM tone) can drive it directly and be verified end-to-end.

Parameters:
DATA_W, 24, sample width per channel
FIFO_DEPTH, 8, stereo pairs buffered; must be a power of 2, minimum 2
SYNC_STAGES, 2, flip-flop stages on AUD_BCLK and AUD_DACLRCK

Ports:
CLOCK_50  in  1  system clock; all logic runs on its rising edge
reset_n  in  1  asynchronous, active-low reset
write  in  1  push request for one stereo pair
writedata_left  in  DATA_W  left sample, signed two's complement
writedata_right  in  DATA_W  right sample
write_ready  out  1  high when the FIFO can accept a pair
AUD_BCLK  in  1  codec bit clock, asynchronous to CLOCK_50
AUD_DACLRCK  in  1  codec frame clock: low = left channel, high = right channel
AUD_DACDAT  out  1  serial DAC data
fifo_count  out  $clog2(FIFO_DEPTH)+1  pairs currently buffered
underflow  out  1  one-cycle pulse when a frame starts with the FIFO empty

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - AUD_DACDAT=0, fifo_count=0, write_ready=1, underflow=0.
  - FSM goes to ALIGN; shift register, bit counter and synchronizers are cleared.
- Synchronizers: AUD_BCLK and AUD_DACLRCK pass through SYNC_STAGES flops.
  - bclk_fall is a one-cycle strobe on a synchronized 1->0 transition of BCLK.
  - The LRCK level is sampled only on a bclk_fall cycle; lr_prev holds the previous sample.
- Push side:
  - write_ready = (fifo_count != FIFO_DEPTH), combinational from the count.
  - A push occurs only when write && write_ready; a write while full is dropped silently, with no FIFO change.
  - Both channels are stored as one entry.
- FSM states: ALIGN, LEFT, RIGHT.
  - ALIGN: AUD_DACDAT=0, no pops. On the first bclk_fall with lr_prev=1 and LRCK=0, pop a pair (or substitute zeros) and go to LEFT.
  - LEFT: on the bclk_fall where lr_prev=0 and LRCK=1, load the latched right sample into the shifter and go to RIGHT.
  - RIGHT: on the bclk_fall where lr_prev=1 and LRCK=0, pop the next pair and go to LEFT.
  - Any other LRCK edge (glitch, or an edge inconsistent with the state) sends the FSM to ALIGN with AUD_DACDAT=0.
- Pop: one pop per frame, taken at the left-channel start.
  - If the FIFO is empty, both latched samples are 0 and underflow pulses for that cycle.
  - fifo_count decrements on the cycle after the pop strobe.
- Serial format (I2S, one-bit delay):
  - On the bclk_fall that detects the channel edge, AUD_DACDAT still shows the last bit of the previous slot, or 0.
  - On the next bclk_fall, AUD_DACDAT takes the MSB.
  - Each following bclk_fall shifts out the next bit, MSB first, for DATA_W bits.
  - After DATA_W bits AUD_DACDAT=0 until the next channel edge.
  - If a channel slot is shorter than DATA_W+1 BCLKs, the remaining bits are truncated at the next edge.
- AUD_DACDAT is registered and changes only on CLOCK_50 cycles where bclk_fall=1.
- Simultaneous push and pop:
  - Full: the pop proceeds; the push is rejected because write_ready was already 0 that cycle. Count becomes FIFO_DEPTH-1.
  - Empty: the pop underflows (zeros are output); the push is stored. Count becomes 1.
  - Otherwise: both proceed and the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
- reset_n asserted mid-frame: immediate return to reset values, buffered samples are discarded, and the FSM realigns on the next left-frame start.
- Latency: a pair pushed into an empty FIFO in ALIGN/RIGHT appears at the next left-frame start. Its MSB reaches AUD_DACDAT one BCLK period after that frame edge, plus synchronizer delay of at most SYNC_STAGES+1 CLOCK_50 cycles.

Decomposition:
- Package audio_pkg holds DATA_W, FIFO_DEPTH, a stereo_sample_t {left,right} type and the FSM state enum, shared with future ADC deserializer work.
- Sub-module audio_sample_fifo: synchronous FIFO of stereo_sample_t with push, pop, full, empty and count, and the simultaneous-access rules above.

Test Plan:
- Reset check: hold reset_n=0 with BCLK toggling -> AUD_DACDAT=0, write_ready=1, fifo_count=0, underflow=0. Release reset -> no data appears before the first LRCK 1->0 edge.
- Single frame: push L=24'hA5_0F3C, R=24'h80_0001; run 64 BCLK/frame -> left slot shows 1 idle bit then 101001010000111100111100; right slot shows 1 idle bit then 100000000000000000000001; rest of each slot 0. fifo_count goes 1->0 at the pop.
- Underflow: run 2 frames with no pushes -> AUD_DACDAT all 0; underflow pulses exactly once per left-frame start (2 pulses).
- Backpressure: push 9 pairs back-to-back with no frames running -> write_ready falls after the 8th push; the 9th is dropped; fifo_count=8. After 8 frames the output order matches pushes 1-8.
- Simultaneous: with fifo_count=8, assert write on the pop cycle -> count=7, the extra pair is dropped. With fifo_count=0, assert write on the pop cycle -> zeros output, underflow=1, count=1.
- Mid-frame reset: assert reset_n=0 during bit 10 of the left slot, release after 3 cycles -> AUD_DACDAT=0 until the next left-frame edge, fifo_count=0, and a new push is output correctly on the following frame.
